// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and WIDTH limits.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        SUB_IDLE = 2'd0,
        SUB_BUSY = 2'd1,
        SUB_DONE = 2'd2
    } sub_state_t;

    // Legal range for the WIDTH parameter of serial_subtractor.
    localparam int SUB_WIDTH_MIN = 2;
    localparam int SUB_WIDTH_MAX = 32;

endpackage

// File: rtl/full_subtractor_bitwise.sv
// Single-bit full subtractor cell: d = a - b - bin, with borrow out.
// Latency: combinational.
// Backpressure: none.
// Ports:
//   a, b  - minuend / subtrahend bit
//   bin   - incoming borrow
//   d     - difference bit
//   bout  - outgoing borrow
module full_subtractor_bitwise (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, one bit per clock LSB first, through one full-subtractor cell.
// Latency: WIDTH cycles from accepted start to done; initiation interval WIDTH+2.
// Backpressure: start is only honoured while ready=1; it is ignored in BUSY and DONE.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   start, a, b     - request and operands, captured on start while ready
//   ready/busy/done - FSM status (done is a one-cycle pulse)
//   diff,borrow_out - result modulo 2^WIDTH and final borrow, held until the next start
//   ovf             - signed overflow, present only when SERIAL_SUB_OVF_EN is defined
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    if (WIDTH < SUB_WIDTH_MIN || WIDTH > SUB_WIDTH_MAX) begin : g_width_check
        $error("serial_subtractor: WIDTH outside legal range");
    end

    sub_state_t        state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              bw_q, bw_d;
    logic              borrow_out_q, borrow_out_d;
`ifdef SERIAL_SUB_OVF_EN
    logic              ovf_q, ovf_d;
`endif

    logic              fs_d;
    logic              fs_bout;
    logic              last_bit;

    full_subtractor_bitwise u_fsub (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (bw_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    // Counter starts at 0 on accept, so the WIDTH-th busy edge sees WIDTH-1.
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SUB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SUB_IDLE: if (start) state_d = SUB_BUSY;
            SUB_BUSY: if (last_bit) state_d = SUB_DONE;
            SUB_DONE: state_d = SUB_IDLE;
            default:  state_d = SUB_IDLE;
        endcase
    end

    // Output decode; depends only on the state register.
    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state_q)
            SUB_IDLE: ready = 1'b1;
            SUB_BUSY: busy  = 1'b1;
            SUB_DONE: done  = 1'b1;
            default:  ready = 1'b0;
        endcase
    end

    // Datapath next values.
    always_comb begin
        a_d          = a_q;
        b_d          = b_q;
        diff_d       = diff_q;
        cnt_d        = cnt_q;
        bw_d         = bw_q;
        borrow_out_d = borrow_out_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d        = ovf_q;
`endif
        case (state_q)
            SUB_IDLE: begin
                if (start) begin
                    a_d          = a;
                    b_d          = b;
                    diff_d       = '0;
                    cnt_d        = '0;
                    bw_d         = 1'b0;
                    borrow_out_d = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d        = 1'b0;
`endif
                end
            end
            SUB_BUSY: begin
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                // New bit enters at the MSB; after WIDTH shifts bit 0 lands in diff[0].
                diff_d = {fs_d, diff_q[WIDTH-1:1]};
                cnt_d  = cnt_q + 1'b1;
                bw_d   = fs_bout;
                if (last_bit) begin
                    borrow_out_d = fs_bout;
`ifdef SERIAL_SUB_OVF_EN
                    // On the last edge the operand LSBs are the captured sign bits
                    // and fs_d is the result sign bit.
                    ovf_d = (a_q[0] != b_q[0]) && (fs_d != a_q[0]);
`endif
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q          <= '0;
            b_q          <= '0;
            diff_q       <= '0;
            cnt_q        <= '0;
            bw_q         <= 1'b0;
            borrow_out_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q        <= 1'b0;
`endif
        end else begin
            a_q          <= a_d;
            b_q          <= b_d;
            diff_q       <= diff_d;
            cnt_q        <= cnt_d;
            bw_q         <= bw_d;
            borrow_out_q <= borrow_out_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q        <= ovf_d;
`endif
        end
    end

    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf        = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor: directed cases plus random operands vs. an arithmetic model.
// Latency: expects done WIDTH cycles after the accepting edge.
// Backpressure: exercises start held high through BUSY and DONE.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         ovf_obs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf        (ovf_obs)
`endif
    );

`ifndef SERIAL_SUB_OVF_EN
    assign ovf_obs = 1'b0;
`endif

    // Model: {borrow, diff} is the (W+1)-bit result of an unsigned subtraction.
    function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] r;
        r = {1'b0, x} - {1'b0, y};
        return r;
    endfunction

    // Model: signed overflow means the true signed difference does not fit in W bits.
    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
        int s;
`ifdef SERIAL_SUB_OVF_EN
        s = int'($signed(x)) - int'($signed(y));
        return (s > (2 ** (W - 1)) - 1) || (s < -(2 ** (W - 1)));
`else
        s = int'(x) - int'(y);
        return (s != s);
`endif
    endfunction

    // Drives one operation from a negedge and reports what was observed.
    task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                          output logic busy0, output int lat,
                          output logic [W-1:0] d_done, output logic bo_done, output logic ov_done,
                          output logic rdy_after, output logic done_after,
                          output logic [W-1:0] d_after);
        int guard;
        guard = 0;
        while (!ready && guard < 4 * W) begin
            @(negedge clk);
            guard++;
        end
        a = xa;
        b = xb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy0 = busy;
        lat = 0;
        while (!done && lat < 4 * W) begin
            a = W'($urandom);
            b = W'($urandom);
            @(negedge clk);
            lat++;
        end
        d_done  = diff;
        bo_done = borrow_out;
        ov_done = ovf_obs;
        @(negedge clk);
        rdy_after  = ready;
        done_after = done;
        d_after    = diff;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (diff !== '0) begin errors++; $display("FAIL reset_diff got %h want 0", diff); end
        checks++; if (borrow_out !== 1'b0) begin errors++; $display("FAIL reset_borrow got %b want 0", borrow_out); end
        checks++; if (ovf_obs !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf_obs); end
    endtask

    // Directed operand pair with full timing and result checks.
    task automatic test_directed(input string name, input logic [W-1:0] xa, input logic [W-1:0] xb);
        logic busy0, bo, ov, rdy, dn;
        logic [W-1:0] d, d2;
        logic [W:0] exp;
        int lat;
        exp = ref_sub(xa, xb);
        run_op(xa, xb, busy0, lat, d, bo, ov, rdy, dn, d2);
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL %s_busy got %b want 1", name, busy0); end
        checks++; if (lat != W) begin errors++; $display("FAIL %s_latency got %0d want %0d", name, lat, W); end
        checks++; if (d !== exp[W-1:0]) begin errors++; $display("FAIL %s_diff got %h want %h", name, d, exp[W-1:0]); end
        checks++; if (bo !== exp[W]) begin errors++; $display("FAIL %s_borrow got %b want %b", name, bo, exp[W]); end
`ifdef SERIAL_SUB_OVF_EN
        checks++; if (ov !== ref_ovf(xa, xb)) begin errors++; $display("FAIL %s_ovf got %b want %b", name, ov, ref_ovf(xa, xb)); end
`endif
        checks++; if (rdy !== 1'b1 || dn !== 1'b0) begin errors++; $display("FAIL %s_idle_after got ready=%b done=%b want ready=1 done=0", name, rdy, dn); end
        checks++; if (d2 !== exp[W-1:0]) begin errors++; $display("FAIL %s_diff_held got %h want %h", name, d2, exp[W-1:0]); end
    endtask

    task automatic test_start_held();
        int done_cyc[$];
        logic [W-1:0] done_diff[$];
        int guard;
        for (int c = 0; c < 3 * (W + 2); c++) begin
            if (done) begin
                done_cyc.push_back(c);
                done_diff.push_back(diff);
            end
            start = 1'b1;
            if (ready) begin
                a = W'(200);
                b = W'(50);
            end else begin
                a = W'($urandom);
                b = W'($urandom);
            end
            @(negedge clk);
        end
        start = 1'b0;
        checks++; if (done_cyc.size() < 2) begin errors++; $display("FAIL held_done_count got %0d want >=2", done_cyc.size()); end
        if (done_cyc.size() >= 2) begin
            checks++; if (done_cyc[1] - done_cyc[0] != W + 2) begin errors++; $display("FAIL held_interval got %0d want %0d", done_cyc[1] - done_cyc[0], W + 2); end
            checks++; if (done_diff[0] !== W'(150)) begin errors++; $display("FAIL held_diff0 got %h want %h", done_diff[0], W'(150)); end
            checks++; if (done_diff[1] !== W'(150)) begin errors++; $display("FAIL held_diff1 got %h want %h", done_diff[1], W'(150)); end
        end
        guard = 0;
        while (!ready && guard < 4 * W) begin
            @(negedge clk);
            guard++;
        end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL held_return_idle got %b want 1", ready); end
    endtask

    task automatic test_reset_mid();
        logic saw_done;
        a = W'($urandom);
        b = W'($urandom);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got %b want 1", busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst_state got r=%b b=%b d=%b want r=1 b=0 d=0", ready, busy, done); end
        checks++; if (diff !== '0 || borrow_out !== 1'b0 || ovf_obs !== 1'b0) begin errors++; $display("FAIL midrst_outputs got diff=%h bo=%b ovf=%b want 0", diff, borrow_out, ovf_obs); end
        saw_done = 1'b0;
        repeat (W + 2) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL midrst_no_done got %b want 0", saw_done); end
        test_directed("after_rst_7_7", W'(7), W'(7));
    endtask

    task automatic test_random();
        logic [W-1:0] xa, xb;
        for (int i = 0; i < 40; i++) begin
            xa = W'($urandom);
            xb = W'($urandom);
            if (i % 10 == 0) xa = '0;
            if (i % 10 == 1) xb = '1;
            if (i % 10 == 2) xa = {1'b1, {(W - 1){1'b0}}};
            test_directed("random", xa, xb);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        test_reset();
        test_directed("sub_100_37", W'(100), W'(37));
        test_directed("sub_5_9", W'(5), W'(9));
        test_directed("sub_80_01", W'(8'h80), W'(8'h01));
        test_directed("wrap_0_ff", W'(0), W'(8'hFF));
        test_start_held();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
